pwr_evt_logger: RTL and testbench

PWR_EVT_LOGGER -- requirements
Module: pwr_evt_logger

---
 rtl/pwr_evt_logger.sv | 151 +++++++++++++++
 tb/tb_pwr_evt_logger.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pwr_evt_logger.sv
// Purpose: watches per-peripheral power states and logs each transition as {ts, idx, old, new} into an event FIFO.
// Latency: a state change in cycle t reaches the FIFO head in cycle t+2 (empty FIFO, no higher-priority pending).
// Backpressure: evt_pop drains the first-word-fall-through FIFO; a push into a full FIFO without a same-cycle pop is dropped and sets sticky overflow.
//
// Ports:
//   clk, rst_n        - rising-edge clock, synchronous active-low reset
//   state             - per-peripheral 2-bit power state
//   evt_pop           - consumer takes the head entry (ignored when empty)
//   irq_th            - occupancy threshold for irq (0 disables the occupancy term)
//   ovf_clr           - clears the sticky overflow flag
//   evt_valid/evt_data- FIFO non-empty / head entry (zero when empty)
//   evt_count         - FIFO occupancy
//   overflow, irq     - sticky drop flag, registered level interrupt
module pwr_evt_logger #(
    parameter int N     = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N-1:0][1:0]        state,
    input  logic                     evt_pop,
    input  logic [$clog2(DEPTH):0]   irq_th,
    input  logic                     ovf_clr,
    output logic                     evt_valid,
    output logic [31:0]              evt_data,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow,
    output logic                     irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [15:0]         ts_cnt;
    logic [N-1:0][1:0]   prev_state;
    logic [N-1:0]        pending;
    logic [N-1:0][1:0]   snap_old;
    logic [N-1:0][1:0]   snap_new;
    logic [N-1:0][15:0]  snap_ts;

    logic [31:0]         mem [DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;

    logic [N-1:0]        detect;
    logic [N-1:0]        push_sel;
    logic                push_req;
    logic [31:0]         push_dat;
    logic                full;
    logic                pop_ok;
    logic                push_ok;
    logic                drop;
    logic [CW-1:0]       count_nxt;
    logic                ovf_nxt;
    logic                irq_nxt;

    always_comb begin
        detect = '0;
        for (int i = 0; i < N; i++) begin
            detect[i] = (state[i] != prev_state[i]);
        end
    end

    // Fixed-priority pick of the lowest-index pending snapshot.
    always_comb begin
        push_sel = '0;
        push_req = 1'b0;
        push_dat = 32'h0;
        for (int i = 0; i < N; i++) begin
            if (pending[i] && !push_req) begin
                push_req    = 1'b1;
                push_sel[i] = 1'b1;
                push_dat    = {snap_ts[i], 4'h0, 4'(i), 4'h0, snap_old[i], snap_new[i]};
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    always_comb begin
        full    = (evt_count == CW'(DEPTH));
        pop_ok  = evt_pop && (evt_count != '0);
        push_ok = push_req && (!full || pop_ok);
        drop    = push_req && !push_ok;

        count_nxt = evt_count;
        if (push_ok && !pop_ok) begin
            count_nxt = evt_count + 1'b1;
        end else if (!push_ok && pop_ok) begin
            count_nxt = evt_count - 1'b1;
        end

        // A drop in the clearing cycle wins so no loss goes unreported.
        ovf_nxt = (overflow && !ovf_clr) || drop;
        irq_nxt = ((count_nxt >= irq_th) && (irq_th != '0)) || ovf_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_cnt     <= 16'h0;
            prev_state <= '0;
            pending    <= '0;
            snap_old   <= '0;
            snap_new   <= '0;
            snap_ts    <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            evt_count  <= '0;
            overflow   <= 1'b0;
            irq        <= 1'b0;
        end else begin
            ts_cnt     <= ts_cnt + 16'd1;
            prev_state <= state;
            for (int i = 0; i < N; i++) begin
                if (detect[i] && (!pending[i] || push_sel[i])) begin
                    // Fresh snapshot; if the old one is leaving this cycle it
                    // has already been handed to the FIFO write path.
                    pending[i]  <= 1'b1;
                    snap_old[i] <= prev_state[i];
                    snap_new[i] <= state[i];
                    snap_ts[i]  <= ts_cnt;
                end else if (detect[i]) begin
                    // Still waiting: coalesce, keeping the original old/ts.
                    snap_new[i] <= state[i];
                end else if (push_sel[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            evt_count <= count_nxt;
            overflow  <= ovf_nxt;
            irq       <= irq_nxt;
        end
    end

    // Storage needs no reset; pointers and count define what is visible.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Held low during reset so a mid-operation reset hides the queue at once.
    assign evt_valid = rst_n && (evt_count != '0);
    assign evt_data  = evt_valid ? mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_pwr_evt_logger.sv
module tb_pwr_evt_logger;

    logic             clk;
    logic             rst_n;
    logic [3:0][1:0]  st;
    logic             evt_pop;
    logic [3:0]       irq_th;
    logic             ovf_clr;
    logic             evt_valid;
    logic [31:0]      evt_data;
    logic [3:0]       evt_count;
    logic             overflow;
    logic             irq;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    pwr_evt_logger #(.N(4), .DEPTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .state     (st),
        .evt_pop   (evt_pop),
        .irq_th    (irq_th),
        .ovf_clr   (ovf_clr),
        .evt_valid (evt_valid),
        .evt_data  (evt_data),
        .evt_count (evt_count),
        .overflow  (overflow),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task go(input int n);
        while (cyc < n) tick();
    endtask

    initial begin
        rst_n   = 1'b0;
        st      = 8'h00;
        evt_pop = 1'b0;
        irq_th  = 4'd0;
        ovf_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        chk("rst_valid", 32'(evt_valid), 32'h0);
        chk("rst_data",  evt_data,       32'h0);
        chk("rst_count", 32'(evt_count), 32'h0);
        chk("rst_ovf",   32'(overflow),  32'h0);
        chk("rst_irq",   32'(irq),       32'h0);

        rst_n = 1'b1;
        cyc   = 0;

        // Single change on peripheral 2 in cycle 5
        go(5);  st = 8'h20;
        go(6);  chk("lat_t6_valid", 32'(evt_valid), 32'h0);
        go(7);  chk("lat_t7_valid", 32'(evt_valid), 32'h1);
                chk("lat_t7_data",  evt_data,       32'h0005_0202);
                chk("lat_t7_count", 32'(evt_count), 32'h1);
                evt_pop = 1'b1;
        go(8);  evt_pop = 1'b0;
                chk("pop_empty_valid", 32'(evt_valid), 32'h0);
                chk("pop_empty_data",  evt_data,       32'h0);

        // Peripherals 0, 1, 3 change together
                st = 8'h6D;
        go(10); chk("multi_p0", evt_data, 32'h0008_0001);
        go(11); chk("multi_cnt2", 32'(evt_count), 32'h2);
        go(12); chk("multi_cnt3", 32'(evt_count), 32'h3);
                evt_pop = 1'b1;
        go(13); chk("multi_p1", evt_data, 32'h0008_0103);
        go(14); chk("multi_p3", evt_data, 32'h0008_0301);
        go(15); chk("multi_drained", 32'(evt_valid), 32'h0);
        go(16); chk("pop_on_empty_count", 32'(evt_count), 32'h0);
                evt_pop = 1'b0;

        // Coalesce: p1 changes again while waiting behind p0
                st = 8'h62;
        go(17); st = 8'h66;
        go(18); chk("coal_p0", evt_data, 32'h0010_0006);
                evt_pop = 1'b1;
        go(19); chk("coal_p1", evt_data, 32'h0010_010D);
                chk("coal_cnt", 32'(evt_count), 32'h1);
        go(20); chk("coal_drained", 32'(evt_valid), 32'h0);
                evt_pop = 1'b0;

        // Push and new detection on the same index
                st = 8'h67;
        go(21); st = 8'h64;
        go(22); chk("rearm_first", evt_data, 32'h0014_000B);
                chk("rearm_cnt1", 32'(evt_count), 32'h1);
                evt_pop = 1'b1;
        go(23); chk("rearm_second", evt_data, 32'h0015_000C);
                chk("rearm_cnt_pushpop", 32'(evt_count), 32'h1);
        go(24); chk("rearm_drained", 32'(evt_valid), 32'h0);
                evt_pop = 1'b0;

        // Threshold interrupt
                irq_th = 4'd3;
                st = 8'h79;
        go(27); chk("th_cnt2", 32'(evt_count), 32'h2);
                chk("th_irq_below", 32'(irq), 32'h0);
        go(28); chk("th_cnt3", 32'(evt_count), 32'h3);
                chk("th_irq_at", 32'(irq), 32'h1);
                chk("th_head", evt_data, 32'h0018_0001);
                evt_pop = 1'b1;
        go(29); chk("th_cnt_after_pop", 32'(evt_count), 32'h2);
                chk("th_irq_after_pop", 32'(irq), 32'h0);
                evt_pop = 1'b0;
                irq_th = 4'd2;
        go(30); chk("th2_irq", 32'(irq), 32'h1);
                irq_th = 4'd0;
        go(31); chk("th0_irq", 32'(irq), 32'h0);
                evt_pop = 1'b1;
        go(33); chk("th_drained", 32'(evt_count), 32'h0);
                evt_pop = 1'b0;

        // Fill to 8 then overflow
                st = 8'h86;
        go(37); chk("fill_cnt3", 32'(evt_count), 32'h3);
                st = 8'h79;
        go(42); chk("full_cnt", 32'(evt_count), 32'h8);
                chk("full_head", evt_data, 32'h0021_0006);
                chk("full_no_ovf", 32'(overflow), 32'h0);
                st = 8'h78;
        go(43); chk("pre_drop_ovf", 32'(overflow), 32'h0);
                chk("pre_drop_irq", 32'(irq), 32'h0);
        go(44); chk("drop_ovf", 32'(overflow), 32'h1);
                chk("drop_irq", 32'(irq), 32'h1);
                chk("drop_cnt", 32'(evt_count), 32'h8);
                ovf_clr = 1'b1;
        go(45); chk("clr_ovf", 32'(overflow), 32'h0);
                chk("clr_irq", 32'(irq), 32'h0);
                chk("clr_cnt", 32'(evt_count), 32'h8);
                ovf_clr = 1'b0;

        // Full FIFO with push and pop together
                st = 8'h7C;
        go(46); evt_pop = 1'b1;
        go(47); chk("fullpp_cnt", 32'(evt_count), 32'h8);
                chk("fullpp_ovf", 32'(overflow), 32'h0);
                chk("fullpp_head", evt_data, 32'h0021_0109);
        go(50); evt_pop = 1'b0;
                chk("pre_rst_cnt", 32'(evt_count), 32'h5);
                st = 8'h8C;

        // Reset with entries queued and pending
        go(51); rst_n = 1'b0;
                #1;
                chk("in_rst_valid", 32'(evt_valid), 32'h0);
                chk("in_rst_data",  evt_data,       32'h0);
        tick(); chk("post_rst_cnt",   32'(evt_count), 32'h0);
                chk("post_rst_valid", 32'(evt_valid), 32'h0);
                chk("post_rst_ovf",   32'(overflow),  32'h0);
                chk("post_rst_irq",   32'(irq),       32'h0);
                rst_n = 1'b1;
                cyc   = 0;
        go(1);  chk("rel_no_stale_valid", 32'(evt_valid), 32'h0);
                chk("rel_no_stale_cnt",   32'(evt_count), 32'h0);
        go(2);  chk("rel_p1", evt_data, 32'h0000_0103);
                chk("rel_cnt1", 32'(evt_count), 32'h1);
        go(3);  chk("rel_cnt2", 32'(evt_count), 32'h2);
                evt_pop = 1'b1;
        go(4);  chk("rel_p3", evt_data, 32'h0000_0302);
        go(5);  chk("rel_drained", 32'(evt_count), 32'h0);
                evt_pop = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
